instr_encoder: RTL

Assembles RV32I instruction words from decoded fields and streams them into instruction memory at consecutive word addresses. It is the encode-side counterpart of the pipeline's opcode decoder, used by the program loader and test harness to fill instruction memory before the core is released from reset. Input is a valid/ready field stream. Output is a one-deep registered write port with backpressure.

---
 rtl/instr_encoder.sv | 119 +++++++++++
 1 files changed

// File: rtl/instr_encoder.sv
// instr_encoder: packs decoded RV32I fields into instruction words and
// streams them to instruction memory at consecutive word addresses.
// Field-set input uses valid/ready. The write port is a one-deep output
// register that holds its word while memory stalls.
module instr_encoder #(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                DEPTH     = 256,
  localparam int               CW        = $clog2(DEPTH + 1)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [2:0]        i_fmt,
  input  logic [6:0]        i_opcode,
  input  logic [4:0]        i_rd,
  input  logic [4:0]        i_rs1,
  input  logic [4:0]        i_rs2,
  input  logic [2:0]        i_funct3,
  input  logic [6:0]        i_funct7,
  input  logic [31:0]       i_imm,
  output logic              o_imem_we,
  output logic [ADDR_W-1:0] o_imem_addr,
  output logic [31:0]       o_imem_wdata,
  input  logic              i_imem_rdy,
  output logic [CW-1:0]     o_count,
  output logic              o_full,
  output logic              o_err
);

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;

  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [CW-1:0]     r_count;
  logic              r_err;

  logic              w_full;
  logic              w_ready;
  logic              w_accept;
  logic              w_drop;
  logic [CW-1:0]     w_count_eff;
  logic [ADDR_W-1:0] w_addr;
  logic [31:0]       w_word;

  assign w_full   = (r_count == CW'(DEPTH));
  // A word may enter when the output register is empty or draining this cycle.
  assign w_ready  = !w_full && (!r_we || i_imem_rdy);
  assign w_accept = i_in_valid && w_ready;
  // Illegal formats and misaligned branch/jump targets are consumed but not written.
  assign w_drop   = (i_fmt[2:1] == 2'b11) ||
                    (((i_fmt == FMT_B) || (i_fmt == FMT_J)) && i_imm[0]);
  // A start in the same cycle as an accept makes that word the first of a new run.
  assign w_count_eff = i_start ? '0 : r_count;
  assign w_addr      = BASE_ADDR + ADDR_W'({w_count_eff, 2'b00});

  // Pack the selected format; unused fields never reach the word.
  always_comb begin
    w_word = '0;
    case (i_fmt)
      FMT_R: w_word = {i_funct7, i_rs2, i_rs1, i_funct3, i_rd, i_opcode};
      FMT_I: w_word = {i_imm[11:0], i_rs1, i_funct3, i_rd, i_opcode};
      FMT_S: w_word = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], i_opcode};
      FMT_B: w_word = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3,
                       i_imm[4:1], i_imm[11], i_opcode};
      FMT_U: w_word = {i_imm[31:12], i_rd, i_opcode};
      FMT_J: w_word = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12],
                       i_rd, i_opcode};
      default: w_word = '0;
    endcase
  end

  // Output register: load on a legal accept, hold while stalled, clear once written.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_accept && !w_drop) begin
      r_we    <= 1'b1;
      r_addr  <= w_addr;
      r_wdata <= w_word;
    end else if (i_imem_rdy) begin
      r_we    <= 1'b0;
    end
  end

  // Word count and sticky drop flag; a drop in the start cycle still sets err.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
      r_err   <= 1'b0;
    end else begin
      if (i_start) begin
        r_count <= '0;
        r_err   <= 1'b0;
      end
      if (w_accept && !w_drop) r_count <= w_count_eff + CW'(1);
      if (w_accept && w_drop)  r_err   <= 1'b1;
    end
  end

  assign o_in_ready   = w_ready;
  assign o_imem_we    = r_we;
  assign o_imem_addr  = r_addr;
  assign o_imem_wdata = r_wdata;
  assign o_count      = r_count;
  assign o_full       = w_full;
  assign o_err        = r_err;

endmodule
